// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART frame-format constants for the receiver
package uart_rx_pkg;
  localparam int UART_CLKS_PER_BIT = 104;
  localparam int UART_SYNC_STAGES  = 2;
  localparam int DATA_BITS         = 8;
endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with single-entry hold buffer
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = UART_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LP_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   w_sdin;
  logic                   w_stop_evt;

  assign w_sdin = r_sync[SYNC_STAGES-1];
  assign busy   = (r_state != S_IDLE);

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_stop_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_sdin) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == LP_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_sdin ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == LP_FULL) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_sdin, r_shift[DATA_BITS-1:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == LP_LAST) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == LP_FULL) begin
          w_cnt_nxt   = '0;
          w_stop_evt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A completing byte may replace the held one only if it is popped on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (valid && ack) valid <= 1'b0;
      if (w_stop_evt) begin
        if (!w_sdin) begin
          frame_err <= 1'b1;
        end else if (!valid || ack) begin
          data_out <= r_shift;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .din(din), .data_out(data_out), .valid(valid),
    .ack(ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (CPB) @(negedge clk);
    end
    din = stop_bit;
    repeat (CPB) @(negedge clk);
    din = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hFE; seq[3] = 8'h10; seq[4] = 8'h22;

    repeat (4) @(negedge clk);
    chk("rst_data", {24'd0, data_out}, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single byte, held until ack
    send_frame(8'h55, 1'b1);
    wait_valid("t1_valid");
    chk("t1_data", {24'd0, data_out}, 32'h55);
    repeat (50) @(negedge clk);
    chk("t1_hold", {31'd0, valid}, 32'd1);
    do_ack();
    chk("t1_popped", {31'd0, valid}, 32'd0);
    chk("t1_ferr_cnt", fe_cnt, 32'd0);
    chk("t1_ovr_cnt", ov_cnt, 32'd0);

    // 2: back-to-back frames, consumer acks each
    fork
      begin
        for (int i = 0; i < 5; i++) send_frame(seq[i], 1'b1);
      end
      begin
        for (int j = 0; j < 5; j++) begin
          wait_valid($sformatf("t2_valid%0d", j));
          chk($sformatf("t2_data%0d", j), {24'd0, data_out}, {24'd0, seq[j]});
          do_ack();
        end
      end
    join
    repeat (10) @(negedge clk);
    chk("t2_empty", {31'd0, valid}, 32'd0);
    chk("t2_ovr_cnt", ov_cnt, 32'd0);
    chk("t2_ferr_cnt", fe_cnt, 32'd0);

    // 3: overrun when second byte completes into a full buffer
    send_frame(8'h53, 1'b1);
    send_frame(8'h79, 1'b1);
    repeat (20) @(negedge clk);
    chk("t3_valid", {31'd0, valid}, 32'd1);
    chk("t3_data", {24'd0, data_out}, 32'h53);
    chk("t3_ovr_cnt", ov_cnt, 32'd1);
    chk("t3_ferr_cnt", fe_cnt, 32'd0);
    do_ack();
    chk("t3_popped", {31'd0, valid}, 32'd0);

    // 4: framing error
    send_frame(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_ferr_cnt", fe_cnt, 32'd1);
    chk("t4_valid", {31'd0, valid}, 32'd0);
    chk("t4_data", {24'd0, data_out}, 32'h53);
    chk("t4_ovr_cnt", ov_cnt, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);

    // 5: short glitch rejected in START
    din = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    din = 1'b1;
    @(negedge clk);
    chk("t5_busy_hi", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("t5_busy_lo", {31'd0, busy}, 32'd0);
    chk("t5_valid", {31'd0, valid}, 32'd0);
    chk("t5_ferr_cnt", fe_cnt, 32'd1);
    chk("t5_ovr_cnt", ov_cnt, 32'd1);

    // 6: reset mid-frame abandons 0x3C, then 0x0E arrives intact
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din = (8'h3C >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    chk("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_data", {24'd0, data_out}, 32'h0);
    repeat (CPB * 8) @(negedge clk);
    chk("t6_no_valid", {31'd0, valid}, 32'd0);
    chk("t6_busy_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h0E, 1'b1);
    wait_valid("t6_valid");
    chk("t6_data", {24'd0, data_out}, 32'h0E);
    do_ack();
    chk("t6_ferr_cnt", fe_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
